store_queue: RTL and testbench

- Circular store queue, 2-wide superscalar, downstream of the reorder buffer's retire port.
- Allocates entries for stores at dispatch and captures address/data from the execute stage.
- Gates ROB retirement of stores via `retire_valid`, then drains retired stores in order to the D-cache, one per cycle, over a valid/ready handshake.
- Supports branch rollback by restoring the tail pointer.

---
 rtl/store_queue.sv | 163 ++++++++++++++++
 tb/tb_store_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
`default_nettype none
// store_queue: circular 2-wide store queue between dispatch, ROB retire and the D-cache write port.
// Rev 1.0 - initial release
module store_queue #(
    parameter int NUM_SQ    = 8,
    parameter int NUM_SUPER = 2,
    parameter int SQ_W      = $clog2(NUM_SQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      dispatch_en,
    input  logic [NUM_SUPER-1:0]      dispatch_wr_mem,
    output logic                      SQ_ready,
    output logic [NUM_SUPER*SQ_W-1:0] SQ_idx,
    output logic [SQ_W:0]             SQ_tail,
    input  logic                      ex_en,
    input  logic [SQ_W-1:0]           ex_sq_idx,
    input  logic [63:0]               ex_addr,
    input  logic [63:0]               ex_data,
    input  logic [NUM_SUPER-1:0]      retire_wr_mem,
    input  logic [NUM_SUPER-1:0]      retire_en,
    output logic [NUM_SUPER-1:0]      retire_valid,
    input  logic                      rollback_en,
    input  logic [SQ_W:0]             rollback_sq_tail,
    output logic                      mem_req_valid,
    output logic [63:0]               mem_req_addr,
    output logic [63:0]               mem_req_data,
    input  logic                      mem_req_ready
);
    localparam int            PW       = SQ_W + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] MAX_USED = PW'(NUM_SQ - 2);

    logic [PW-1:0]     head_q, head_d, rptr_q, rptr_d, tail_q, tail_d;
    logic [NUM_SQ-1:0] valid_q, valid_d;
    logic [NUM_SQ-1:0] addr_valid_q, addr_valid_d;
    logic [NUM_SQ-1:0] retired_q, retired_d;
    logic [63:0]       addr_q [NUM_SQ];
    logic [63:0]       data_q [NUM_SQ];

    logic [PW-1:0]     disp_ptr [NUM_SUPER];
    logic [PW-1:0]     disp_tail;
    logic [PW-1:0]     ret_ptr [NUM_SUPER];
    logic [PW-1:0]     ret_scan;
    logic [PW-1:0]     used;
    logic [PW-1:0]     squash_span;
    logic [PW-1:0]     squash_dist;
    logic [SQ_W-1:0]   k_idx;
    logic [SQ_W-1:0]   head_idx;
    logic              ex_fire;
    logic              drain_fire;

    assign head_idx      = head_q[SQ_W-1:0];
    assign used          = tail_q - head_q;
    assign SQ_ready      = (used <= MAX_USED);
    assign SQ_tail       = tail_q;
    assign mem_req_valid = en & valid_q[head_idx] & retired_q[head_idx];
    assign mem_req_addr  = addr_q[head_idx];
    assign mem_req_data  = data_q[head_idx];
    assign drain_fire    = mem_req_valid & mem_req_ready;
    assign ex_fire       = en & ex_en & valid_q[ex_sq_idx] & ~retired_q[ex_sq_idx];

    // Slot i of a group targets the base pointer plus the number of stores in lower slots.
    always_comb begin
        disp_tail    = tail_q;
        ret_scan     = rptr_q;
        SQ_idx       = '0;
        retire_valid = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            disp_ptr[i]            = disp_tail;
            SQ_idx[i*SQ_W +: SQ_W] = disp_tail[SQ_W-1:0];
            if (dispatch_wr_mem[i]) begin
                disp_tail = disp_tail + PTR_ONE;
            end
            ret_ptr[i]      = ret_scan;
            retire_valid[i] = ~retire_wr_mem[i] | addr_valid_q[ret_scan[SQ_W-1:0]];
            if (retire_wr_mem[i]) begin
                ret_scan = ret_scan + PTR_ONE;
            end
        end
    end

    always_comb begin
        head_d       = head_q;
        rptr_d       = rptr_q;
        tail_d       = tail_q;
        valid_d      = valid_q;
        addr_valid_d = addr_valid_q;
        retired_d    = retired_q;
        squash_span  = tail_q - rollback_sq_tail;
        squash_dist  = '0;
        k_idx        = '0;
        if (en) begin
            if (rollback_en) begin
                tail_d = rollback_sq_tail;
            end else if (dispatch_en) begin
                for (int i = 0; i < NUM_SUPER; i++) begin
                    if (dispatch_wr_mem[i]) begin
                        valid_d[disp_ptr[i][SQ_W-1:0]]      = 1'b1;
                        addr_valid_d[disp_ptr[i][SQ_W-1:0]] = 1'b0;
                        retired_d[disp_ptr[i][SQ_W-1:0]]    = 1'b0;
                    end
                end
                tail_d = disp_tail;
            end
            if (ex_fire) begin
                addr_valid_d[ex_sq_idx] = 1'b1;
            end
            // Squash after the execute write so a write to a squashed entry is lost.
            if (rollback_en) begin
                for (int k = 0; k < NUM_SQ; k++) begin
                    k_idx       = SQ_W'(k);
                    squash_dist = {1'b0, k_idx - rollback_sq_tail[SQ_W-1:0]};
                    if ((squash_dist < squash_span) && !retired_q[k]) begin
                        valid_d[k]      = 1'b0;
                        addr_valid_d[k] = 1'b0;
                    end
                end
            end
            for (int i = 0; i < NUM_SUPER; i++) begin
                if (retire_en[i] && retire_wr_mem[i]) begin
                    retired_d[ret_ptr[i][SQ_W-1:0]] = 1'b1;
                    rptr_d = rptr_d + PTR_ONE;
                end
            end
            if (drain_fire) begin
                valid_d[head_idx]      = 1'b0;
                addr_valid_d[head_idx] = 1'b0;
                retired_d[head_idx]    = 1'b0;
                head_d                 = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            rptr_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            addr_valid_q <= '0;
            retired_q    <= '0;
        end else begin
            head_q       <= head_d;
            rptr_q       <= rptr_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            addr_valid_q <= addr_valid_d;
            retired_q    <= retired_d;
        end
    end

    // Payload needs no reset: it is only observed behind the valid/retired flags.
    always_ff @(posedge clock) begin
        if (ex_fire) begin
            addr_q[ex_sq_idx] <= ex_addr;
            data_q[ex_sq_idx] <= ex_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// tb_store_queue: scoreboard-driven self-checking bench for store_queue.
module tb_store_queue;
    logic        clock;
    logic        reset;
    logic        en;
    logic        dispatch_en;
    logic [1:0]  dispatch_wr_mem;
    logic        SQ_ready;
    logic [5:0]  SQ_idx;
    logic [3:0]  SQ_tail;
    logic        ex_en;
    logic [2:0]  ex_sq_idx;
    logic [63:0] ex_addr;
    logic [63:0] ex_data;
    logic [1:0]  retire_wr_mem;
    logic [1:0]  retire_en;
    logic [1:0]  retire_valid;
    logic        rollback_en;
    logic [3:0]  rollback_sq_tail;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic        mem_req_ready;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } req_t;

    req_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    store_queue #(.NUM_SQ(8), .NUM_SUPER(2)) dut (
        .clock(clock), .reset(reset), .en(en),
        .dispatch_en(dispatch_en), .dispatch_wr_mem(dispatch_wr_mem),
        .SQ_ready(SQ_ready), .SQ_idx(SQ_idx), .SQ_tail(SQ_tail),
        .ex_en(ex_en), .ex_sq_idx(ex_sq_idx), .ex_addr(ex_addr), .ex_data(ex_data),
        .retire_wr_mem(retire_wr_mem), .retire_en(retire_en), .retire_valid(retire_valid),
        .rollback_en(rollback_en), .rollback_sq_tail(rollback_sq_tail),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A handshake visible at the falling edge completes on the next rising edge.
    always @(negedge clock) begin : mon
        req_t e;
        if (!reset && mem_req_valid && mem_req_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("drain_addr", mem_req_addr, e.addr);
                check("drain_data", mem_req_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        dispatch_en      = 1'b0;
        dispatch_wr_mem  = 2'b00;
        ex_en            = 1'b0;
        ex_sq_idx        = 3'd0;
        ex_addr          = 64'd0;
        ex_data          = 64'd0;
        retire_wr_mem    = 2'b00;
        retire_en        = 2'b00;
        rollback_en      = 1'b0;
        rollback_sq_tail = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b1;
        idle();
        sb.delete();
        mem_req_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic dispatch(input logic [1:0] wr);
        dispatch_en     = 1'b1;
        dispatch_wr_mem = wr;
        tick();
        dispatch_en     = 1'b0;
        dispatch_wr_mem = 2'b00;
    endtask

    task automatic ex_write(input logic [2:0] idx, input logic [63:0] a, input logic [63:0] d);
        ex_en     = 1'b1;
        ex_sq_idx = idx;
        ex_addr   = a;
        ex_data   = d;
        tick();
        ex_en     = 1'b0;
    endtask

    task automatic retire_pair(input logic [63:0] a0, input logic [63:0] d0,
                               input logic [63:0] a1, input logic [63:0] d1);
        retire_wr_mem = 2'b11;
        retire_en     = 2'b11;
        sb.push_back(req_t'{a0, d0});
        sb.push_back(req_t'{a1, d1});
        tick();
        retire_wr_mem = 2'b00;
        retire_en     = 2'b00;
    endtask

    task automatic drain_wait();
        int n = 0;
        while ((sb.size() != 0 || mem_req_valid) && n < 40) begin
            tick();
            n++;
        end
        check("drain_done", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_head(input string tag, input logic [63:0] a, input logic [63:0] d);
        check({tag, "_valid"}, 64'(mem_req_valid), 64'd1);
        check({tag, "_addr"}, mem_req_addr, a);
        check({tag, "_data"}, mem_req_data, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset state and first dispatch group
        dispatch_wr_mem = 2'b11;
        settle();
        check("rst_ready", 64'(SQ_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rst_tail", 64'(SQ_tail), 64'd0);
        check("rst_idx", 64'(SQ_idx), 64'({3'd1, 3'd0}));
        check("rst_retire_valid", 64'(retire_valid), 64'b11);
        dispatch(2'b11);
        check("tail_after_pair", 64'(SQ_tail), 64'd2);
        check("ready_after_pair", 64'(SQ_ready), 64'd1);

        // Fill to 8, then drain one and two
        dispatch(2'b11);
        check("ready_used4", 64'(SQ_ready), 64'd1);
        dispatch(2'b11);
        dispatch(2'b11);
        check("full_tail", 64'(SQ_tail), 64'd8);
        check("full_ready", 64'(SQ_ready), 64'd0);
        for (int k = 0; k < 8; k++) ex_write(3'(k), 64'h100 + 64'(k), 64'hA000 + 64'(k));
        mem_req_ready = 1'b0;
        retire_wr_mem = 2'b11;
        settle();
        check("full_retire_valid", 64'(retire_valid), 64'b11);
        retire_pair(64'h100, 64'hA000, 64'h101, 64'hA001);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        settle();
        check("ready_used7", 64'(SQ_ready), 64'd0);
        mem_req_ready = 1'b1;
        tick();
        check("ready_used6", 64'(SQ_ready), 64'd1);
        for (int p = 1; p < 4; p++)
            retire_pair(64'h100 + 64'(2*p), 64'hA000 + 64'(2*p),
                        64'h101 + 64'(2*p), 64'hA001 + 64'(2*p));
        drain_wait();

        // Retire gating, drain latency and backpressure
        dispatch(2'b01);
        retire_wr_mem = 2'b01;
        settle();
        check("gate_blocked", 64'(retire_valid), 64'b10);
        ex_write(3'd0, 64'h1000, 64'hDEAD);
        check("gate_open", 64'(retire_valid), 64'b11);
        mem_req_ready = 1'b0;
        retire_en     = 2'b01;
        sb.push_back(req_t'{64'h1000, 64'hDEAD});
        tick();
        retire_en     = 2'b00;
        retire_wr_mem = 2'b00;
        settle();
        check_head("req_first", 64'h1000, 64'hDEAD);
        dispatch(2'b01);
        check_head("hold1", 64'h1000, 64'hDEAD);
        ex_write(3'd1, 64'h2000, 64'hBEEF);
        check_head("hold2", 64'h1000, 64'hDEAD);
        retire_wr_mem = 2'b01;
        retire_en     = 2'b01;
        sb.push_back(req_t'{64'h2000, 64'hBEEF});
        tick();
        retire_wr_mem = 2'b00;
        retire_en     = 2'b00;
        check_head("hold3", 64'h1000, 64'hDEAD);
        mem_req_ready = 1'b1;
        tick();
        check_head("req_second", 64'h2000, 64'hBEEF);
        tick();
        check("empty_after_two", 64'(mem_req_valid), 64'd0);
        check("tail_after_two", 64'(SQ_tail), 64'd10);

        // Rollback squashes entries 3..5, older retired entries still drain
        do_reset();
        repeat (3) dispatch(2'b11);
        for (int k = 0; k < 6; k++) ex_write(3'(k), 64'h300 + 64'(k), 64'hB000 + 64'(k));
        retire_pair(64'h300, 64'hB000, 64'h301, 64'hB001);
        retire_wr_mem = 2'b11;
        settle();
        check("pre_rb_retire_valid", 64'(retire_valid), 64'b11);
        retire_wr_mem    = 2'b00;
        rollback_en      = 1'b1;
        rollback_sq_tail = 4'd3;
        dispatch_en      = 1'b1;
        dispatch_wr_mem  = 2'b11;
        tick();
        idle();
        check("rb_tail", 64'(SQ_tail), 64'd3);
        retire_wr_mem = 2'b11;
        settle();
        check("rb_retire_valid", 64'(retire_valid), 64'b01);
        retire_wr_mem = 2'b00;
        drain_wait();
        dispatch_wr_mem = 2'b01;
        settle();
        check("rb_next_idx", 64'(SQ_idx[2:0]), 64'd3);
        dispatch_wr_mem = 2'b00;

        // Wrap-around: head=tail=6, then four stores at 6,7,0,1
        do_reset();
        repeat (3) dispatch(2'b11);
        for (int k = 0; k < 6; k++) ex_write(3'(k), 64'h500 + 64'(k), 64'hC000 + 64'(k));
        for (int p = 0; p < 3; p++)
            retire_pair(64'h500 + 64'(2*p), 64'hC000 + 64'(2*p),
                        64'h501 + 64'(2*p), 64'hC001 + 64'(2*p));
        drain_wait();
        dispatch_wr_mem = 2'b11;
        settle();
        check("wrap_idx_a", 64'(SQ_idx), 64'({3'd7, 3'd6}));
        dispatch(2'b11);
        dispatch_wr_mem = 2'b11;
        settle();
        check("wrap_idx_b", 64'(SQ_idx), 64'({3'd1, 3'd0}));
        dispatch(2'b11);
        check("wrap_tail", 64'(SQ_tail), 64'd10);
        ex_write(3'd6, 64'h606, 64'hD006);
        ex_write(3'd7, 64'h607, 64'hD007);
        ex_write(3'd0, 64'h600, 64'hD000);
        ex_write(3'd1, 64'h601, 64'hD001);
        retire_pair(64'h606, 64'hD006, 64'h607, 64'hD007);
        retire_pair(64'h600, 64'hD000, 64'h601, 64'hD001);
        drain_wait();
        check("wrap_end_tail", 64'(SQ_tail), 64'd10);
        check("wrap_end_head", 64'(dut.head_q), 64'd10);
        check("wrap_end_valid", 64'(mem_req_valid), 64'd0);
        check("wrap_end_ready", 64'(SQ_ready), 64'd1);

        // Global enable gating and asynchronous reset mid-drain
        dispatch(2'b01);
        ex_write(3'd2, 64'h700, 64'h7777);
        mem_req_ready = 1'b0;
        retire_wr_mem = 2'b01;
        retire_en     = 2'b01;
        sb.push_back(req_t'{64'h700, 64'h7777});
        tick();
        retire_wr_mem = 2'b00;
        retire_en     = 2'b00;
        check_head("pre_reset", 64'h700, 64'h7777);
        en = 1'b0;
        settle();
        check("en_low_valid", 64'(mem_req_valid), 64'd0);
        en = 1'b1;
        settle();
        reset = 1'b1;
        sb.delete();
        settle();
        check("async_rst_valid", 64'(mem_req_valid), 64'd0);
        check("async_rst_tail", 64'(SQ_tail), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mem_req_ready = 1'b1;
        settle();
        check("post_rst_ready", 64'(SQ_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
